// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the two-port adder arbiter.
package adder_arb_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned OV_CNT_W = 8;

    typedef logic port_id_t;

    // Port 1 as the initial "last grant" makes port 0 win the first conflict.
    localparam port_id_t RR_RESET_GRANT = 1'b1;

    localparam logic [OV_CNT_W-1:0] OV_CNT_MAX = '1;

    // Registered response payload.
    typedef struct packed {
        port_id_t          id;
        logic [DATA_W-1:0] sum;
        logic              zr;
        logic              neg;
        logic              ov;
    } rsp_t;

endpackage

// File: rtl/adder.sv
// 16-bit signed saturating adder (combinational).
// Ports: a, b        operands
//        sum_c       clamped sum (7FFF / 8000 on overflow)
//        zr_c        raw wrapped sum == 0 (before clamping)
//        neg_c       sign of the clamped sum
//        ov_c        signed overflow
module adder
    import adder_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum_c,
    output logic              zr_c,
    output logic              neg_c,
    output logic              ov_c
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] raw_c;

    assign raw_c = a + b;

    // Same-sign operands whose raw sum flips sign have overflowed.
    assign ov_c  = (a[MSB] == b[MSB]) & (raw_c[MSB] != a[MSB]);

    always_comb begin
        sum_c = raw_c;
        if (ov_c) begin
            sum_c = a[MSB] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    assign zr_c  = (raw_c == '0);
    assign neg_c = sum_c[MSB];

endmodule

// File: rtl/adder_arbiter.sv
// Shares one saturating adder between two valid/ready requesters and returns
// tagged results through a single-entry registered output stage.
// Ports: clk, rst (sync, active-high)
//        req0_* / req1_*   request handshakes and operands (rdy is combinational on vld)
//        rsp_*             registered result, flags and originating port id
//        ov_cnt            saturating count of delivered overflow results
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned W          = 16,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_vld,
    output logic                req0_rdy,
    input  logic [W-1:0]        req0_a,
    input  logic [W-1:0]        req0_b,
    input  logic                req1_vld,
    output logic                req1_rdy,
    input  logic [W-1:0]        req1_a,
    input  logic [W-1:0]        req1_b,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic                rsp_id,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_zr,
    output logic                rsp_neg,
    output logic                rsp_ov,
    output logic [OV_CNT_W-1:0] ov_cnt
);

    logic              can_accept_c;
    logic              accept_c;
    logic              drain_c;
    port_id_t          winner_c;
    port_id_t          last_grant;
    rsp_t              rsp_q;
    logic [W-1:0]      op_a_c;
    logic [W-1:0]      op_b_c;
    logic [W-1:0]      sum_c;
    logic              zr_c;
    logic              neg_c;
    logic              ov_c;

    // Output stage can take a new result when empty or draining this cycle.
    assign can_accept_c = ~rst & (~rsp_vld | rsp_rdy);

    // Winner: lone requester, else fixed port 0 or the port not granted last.
    always_comb begin
        winner_c = 1'b0;
        if (req0_vld & req1_vld) begin
            winner_c = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else if (req1_vld) begin
            winner_c = 1'b1;
        end
    end

    assign req0_rdy = can_accept_c & req0_vld & (winner_c == 1'b0);
    assign req1_rdy = can_accept_c & req1_vld & (winner_c == 1'b1);
    assign accept_c = req0_rdy | req1_rdy;
    assign drain_c  = rsp_vld & rsp_rdy;

    assign op_a_c = winner_c ? req1_a : req0_a;
    assign op_b_c = winner_c ? req1_b : req0_b;

    adder u_adder (
        .a     (op_a_c),
        .b     (op_b_c),
        .sum_c (sum_c),
        .zr_c  (zr_c),
        .neg_c (neg_c),
        .ov_c  (ov_c)
    );

    // Output register, grant history and overflow counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld    <= 1'b0;
            rsp_q      <= '0;
            last_grant <= RR_RESET_GRANT;
            ov_cnt     <= '0;
        end else begin
            if (accept_c) begin
                rsp_vld    <= 1'b1;
                rsp_q      <= '{id: winner_c, sum: sum_c, zr: zr_c, neg: neg_c, ov: ov_c};
                last_grant <= winner_c;
            end else if (drain_c) begin
                rsp_vld <= 1'b0;
            end
            if (drain_c & rsp_q.ov & (ov_cnt != OV_CNT_MAX)) begin
                ov_cnt <= ov_cnt + OV_CNT_W'(1);
            end
        end
    end

    assign rsp_id  = rsp_q.id;
    assign rsp_sum = rsp_q.sum;
    assign rsp_zr  = rsp_q.zr;
    assign rsp_neg = rsp_q.neg;
    assign rsp_ov  = rsp_q.ov;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized scoreboard bench for adder_arbiter (round-robin configuration).
module tb_adder_arbiter;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        zr;
        logic        neg;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_vld = 1'b0, req1_vld = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_vld, rsp_rdy = 1'b0, rsp_id, rsp_zr, rsp_neg, rsp_ov;
    logic [15:0] rsp_sum;
    logic [7:0]  ov_cnt;

    int   chk = 0;
    int   err = 0;
    exp_t sb[$];
    bit   model_full = 1'b0;
    bit   model_last = 1'b1;
    int   wait0 = 0, wait1 = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.W(16), .FIXED_PRIO(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0_vld (req0_vld),
        .req0_rdy (req0_rdy),
        .req0_a   (req0_a),
        .req0_b   (req0_b),
        .req1_vld (req1_vld),
        .req1_rdy (req1_rdy),
        .req1_a   (req1_a),
        .req1_b   (req1_b),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_zr   (rsp_zr),
        .rsp_neg  (rsp_neg),
        .rsp_ov   (rsp_ov),
        .ov_cnt   (ov_cnt)
    );

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        chk++;
        if (act !== req) begin
            err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference result from plain signed arithmetic.
    function automatic exp_t ref_op(input logic id, input logic [15:0] a, input logic [15:0] b);
        exp_t r;
        int   s;
        s     = int'($signed(a)) + int'($signed(b));
        r.id  = id;
        r.ov  = (s > 32767) || (s < -32768);
        if (s > 32767)       r.sum = 16'h7FFF;
        else if (s < -32768) r.sum = 16'h8000;
        else                 r.sum = 16'(s);
        r.zr  = ((s & 32'hFFFF) == 0);
        r.neg = r.sum[15];
        return r;
    endfunction

    // Check handshake outputs against the model, then advance the model.
    task automatic model_check();
        bit can, win, e0, e1;
        can = !rst && (!model_full || rsp_rdy);
        win = (req0_vld && req1_vld) ? !model_last : req1_vld;
        e0  = can && req0_vld && !win;
        e1  = can && req1_vld && win;
        check1("rsp_vld", 32'(rsp_vld), 32'(model_full));
        check1("req0_rdy", 32'(req0_rdy), 32'(e0));
        check1("req1_rdy", 32'(req1_rdy), 32'(e1));
        if (can && req0_vld) begin
            if (req0_rdy) wait0 = 0; else wait0++;
            check1("starve0", 32'(wait0 <= 1), 32'd1);
        end
        if (can && req1_vld) begin
            if (req1_rdy) wait1 = 0; else wait1++;
            check1("starve1", 32'(wait1 <= 1), 32'd1);
        end
        if (rst) begin
            sb.delete();
            model_full = 1'b0;
            model_last = 1'b1;
            wait0 = 0;
            wait1 = 0;
        end else if (e0 || e1) begin
            sb.push_back(ref_op(win, win ? req1_a : req0_a, win ? req1_b : req0_b));
            model_full = 1'b1;
            model_last = win;
        end else if (model_full && rsp_rdy) begin
            model_full = 1'b0;
        end
    endtask

    task automatic step(input bit r, input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                        input bit v1, input logic [15:0] a1, input logic [15:0] b1, input bit rr);
        @(posedge clk);
        #1;
        rst = r; rsp_rdy = rr;
        req0_vld = v0; req0_a = a0; req0_b = b0;
        req1_vld = v1; req1_a = a1; req1_b = b1;
        #6;
        model_check();
    endtask

    function automatic logic [15:0] rand_op();
        logic [15:0] corner[5];
        corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    // Monitor: compare the presented response with the scoreboard head.
    initial begin
        exp_t e;
        int   exp_ov;
        exp_ov = 0;
        forever begin
            @(negedge clk);
            check1("ov_cnt", 32'(ov_cnt), 32'(exp_ov));
            if (rsp_vld) begin
                if (sb.size() == 0) begin
                    chk++;
                    err++;
                    $display("FAIL rsp_unexpected actual=%0h required=none at %0t", rsp_sum, $time);
                end else begin
                    e = sb[0];
                    check1("rsp_id", 32'(rsp_id), 32'(e.id));
                    check1("rsp_sum", 32'(rsp_sum), 32'(e.sum));
                    check1("rsp_zr", 32'(rsp_zr), 32'(e.zr));
                    check1("rsp_neg", 32'(rsp_neg), 32'(e.neg));
                    check1("rsp_ov", 32'(rsp_ov), 32'(e.ov));
                    if (!rst && rsp_rdy) begin
                        void'(sb.pop_front());
                        if (e.ov && exp_ov < 255) exp_ov++;
                    end
                end
            end
            if (rst) exp_ov = 0;
        end
    end

    initial begin
        // Reset with both requesters valid: no ready may be raised.
        step(1, 1, 16'h0001, 16'h0002, 1, 16'h7FFF, 16'h0001, 1);
        step(1, 1, 16'h0001, 16'h0002, 1, 16'h7FFF, 16'h0001, 1);
        step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        check1("reset_sum", 32'(rsp_sum), 32'h0);
        check1("reset_ovcnt", 32'(ov_cnt), 32'h0);

        // Round-robin conflict: 0,1,0,1.
        repeat (4) step(0, 1, 16'h0001, 16'h0002, 1, 16'h7FFF, 16'h0001, 1);

        // Negative saturation with raw zero, then wrap to zero without overflow.
        step(0, 1, 16'h8000, 16'h8000, 0, 16'h0, 16'h0, 1);
        step(0, 0, 16'h0, 16'h0, 1, 16'hFFFF, 16'h0001, 1);

        // Backpressure: hold a result 5 cycles, then drain and accept together.
        step(0, 1, 16'h1234, 16'h1111, 0, 16'h0, 16'h0, 1);
        repeat (5) step(0, 1, 16'h0100, 16'h0200, 1, 16'h0300, 16'h0400, 0);
        step(0, 1, 16'h0100, 16'h0200, 1, 16'h0300, 16'h0400, 1);
        step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);

        // Overflow counter saturation.
        repeat (300) step(0, 1, 16'h7FFF, 16'h7FFF, 0, 16'h0, 16'h0, 1);
        step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        check1("ovcnt_sat", 32'(ov_cnt), 32'hFF);

        // Reset while stalled on an overflow result.
        step(0, 1, 16'h7FFF, 16'h0001, 0, 16'h0, 16'h0, 0);
        repeat (3) step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
        step(1, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
        step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        check1("midstall_sum", 32'(rsp_sum), 32'h0);
        check1("midstall_ovcnt", 32'(ov_cnt), 32'h0);
        step(0, 1, 16'h0005, 16'h0006, 1, 16'h0007, 16'h0008, 1);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step(0, $urandom_range(0, 3) != 0, rand_op(), rand_op(),
                 $urandom_range(0, 3) != 0, rand_op(), rand_op(),
                 $urandom_range(0, 3) != 0);
        end

        // Drain and confirm nothing is left outstanding.
        repeat (3) step(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        check1("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one instance of the team's 16-bit saturating `adder` between two requesters, port 0 (ALU issue) and port 1 (address/branch-target generation). Each port has a valid/ready handshake. A round-robin or fixed-priority grant picks the winner, muxes its operands into the adder, and registers the result and flags in a single-entry output stage with its own valid/ready handshake. Results return on one shared response bus tagged with the originating port. The block also keeps a saturating count of overflow events.

## Interface
Parameters:
- `W`, 16: data width. Only 16 is supported, because it is tied to `adder`.
- `FIXED_PRIO`, 0: 0 selects round-robin; 1 means port 0 always wins a conflict.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_vld`  in  1  port 0 has an operation
- `req0_rdy`  out  1  port 0 accepted this cycle
- `req0_a`, `req0_b`  in  W  port 0 operands
- `req1_vld`, `req1_rdy`, `req1_a`, `req1_b`  same as port 0, for port 1
- `rsp_vld`  out  1  registered result present
- `rsp_rdy`  in  1  consumer takes the result this cycle
- `rsp_id`  out  1  originating port (0/1)
- `rsp_sum`  out  W  saturated sum
- `rsp_zr`, `rsp_neg`, `rsp_ov`  out  1  flags from `adder`
- `ov_cnt`  out  8  overflow events delivered, saturating at 8'hFF

## Operation
- **Output register state:** EMPTY (`rsp_vld`=0) or FULL (`rsp_vld`=1).
- **`can_accept`:** `can_accept = ~rst & (~rsp_vld | rsp_rdy)`.
- **Winner selection:**
  - One valid request: that port wins.
  - Both valid, `FIXED_PRIO`=1: port 0 wins.
  - Both valid, `FIXED_PRIO`=0: the port other than `last_grant` wins.
- **Ready generation:** `reqX_rdy = can_accept & reqX_vld & (winner==X)`. Ready depends combinationally on valid. A requester must not make valid depend on ready.
- **Acceptance (handshake fires):**
  - Winner operands go to `adder`.
  - Sum, flags and id are loaded into the output register.
  - `last_grant` updates to the winner.
- **No acceptance, `rsp_vld & rsp_rdy`:** the register empties.
- **No acceptance, `rsp_vld & ~rsp_rdy`:** the register holds all fields stable (no change while stalled).
- **Flag semantics (inherited from `adder`, not altered):**
  - `ov` is set when both operands have the same sign and the raw sum's sign differs. The output then clamps to 16'h7FFF or 16'h8000.
  - `zr` reflects the raw wrapped sum==0, not the clamped output.
  - `neg` = `rsp_sum[15]`.
- **`ov_cnt`:** increments by 1 on each response handshake (`rsp_vld & rsp_rdy`) whose `rsp_ov`=1. It holds at 8'hFF.
- **Reset:**
  - `rsp_vld`=0, `rsp_id`=0, `rsp_sum`=0, all flags 0, `ov_cnt`=0, `last_grant`=1 (port 0 wins the first conflict).
  - Both `reqX_rdy`=0 during any cycle with `rst`=1.
  - A reset mid-stall discards the held result without a handshake.
- **Starvation bound:** round-robin, with a port holding valid continuously, guarantees acceptance within 2 accept opportunities.

## Timing
- Latency: an operation accepted at edge N appears on `rsp_*` after edge N. That is, `rsp_vld`=1 in cycle N+1.
- Throughput: one operation per cycle when `rsp_rdy`=1 continuously. Accept and drain in the same cycle is allowed.
- No combinational path from `req*_a`/`req*_b` to any output. `req*_rdy` depends combinationally on `req*_vld`, `rsp_vld`, `rsp_rdy` and `rst`.
- `ov_cnt` updates at the edge that completes the response handshake.

## Structure
- Package `adder_arb_pkg`:
  - `port_id_t` (1-bit)
  - `RR_RESET_GRANT` = 1'b1
  - `OV_CNT_W` = 8
- One sub-module instance, the existing `adder`, fed by the winner mux. Arbitration, the output register and the counter stay in `adder_arbiter`.

## Test plan
- **Reset values:** hold `rst` 2 cycles with both valids high. Both rdy must be 0. After release: `rsp_vld`=0, `ov_cnt`=0, and the first conflict grants port 0.
- **Round-robin conflict:** both ports valid continuously, `rsp_rdy`=1. Grants alternate 0,1,0,1. Port 0 gets 0001+0002, so `rsp_sum`=0003, `rsp_id`=0. Port 1 gets 7FFF+0001, so `rsp_sum`=7FFF, `ov`=1, `rsp_id`=1.
- **Saturation, raw-zero flag:** 8000+8000 gives `rsp_sum`=8000, `ov`=1, `zr`=1, `neg`=1. FFFF+0001 gives `rsp_sum`=0000, `zr`=1, `ov`=0.
- **Backpressure:** hold `rsp_rdy`=0 for 5 cycles with a result present. `rsp_*` stay stable and both `req*_rdy`=0. When `rsp_rdy` rises, the held result drains and a new accept happens in the same cycle.
- **`ov_cnt`:** 300 back-to-back overflowing operations reach `ov_cnt`=FF and hold. Overflow results that stall and then receive `rst` do not increment `ov_cnt`.
- **Reset mid-stall:** assert `rst` while FULL. In the next cycle `rsp_vld`=0, `rsp_sum`=0, `last_grant`=1.
